// File: rtl/button_reader.sv
// button_reader: debounces one raw, bouncy, asynchronous key/switch pin and
// reports a clean pressed level plus single-cycle press, release and
// long-press strobes, along with a wrapping 8-bit press counter.
//
// Ports:
//   clk           system clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   btn_in        raw asynchronous pin, may bounce
//   btn_level     debounced level, 1 = pressed
//   press_pulse   one-cycle strobe on an accepted press
//   release_pulse one-cycle strobe on an accepted release
//   long_pulse    one-cycle strobe once a press has been held LONG_PRESS_CYCLES
//   press_count   accepted presses, modulo 256
module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

  // dcnt already holds the number of consecutive samples seen, so the
  // DEBOUNCE_CYCLES-th sample arrives while dcnt == DEBOUNCE_CYCLES-1.
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [DW-1:0] DONE  = DW'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_WAIT = 3'd1,
    PRESSED    = 3'd2,
    LONG       = 3'd3,
    REL_WAIT   = 3'd4
  } state_e;

  // Two-flop synchroniser; resets to the inactive pin level so a key held
  // through reset is seen as a fresh press.
  logic s1_q, s2_q;
  logic p;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= ACTIVE_LOW;
      s2_q <= ACTIVE_LOW;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  assign p = s2_q ^ ACTIVE_LOW;

  state_e          state_q;
  logic [DW-1:0]   dcnt_q;
  logic [HW-1:0]   hcnt_q;
  logic            from_long_q;  // which held state REL_WAIT returns to on a glitch
  logic            level_q, press_q, release_q, long_q;
  logic [7:0]      count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      from_long_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (p) begin
            state_q <= PRESS_WAIT;
            dcnt_q  <= DONE;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state_q <= IDLE;
          end else if (dcnt_q == DLAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
            count_q <= count_q + 8'd1;
            hcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + DONE;
          end
        end
        PRESSED: begin
          if (p) begin
            // hcnt stops at LONG_PRESS_CYCLES: LONG never increments it.
            hcnt_q <= hcnt_q + HW'(1);
            if (hcnt_q == HLAST) begin
              long_q  <= 1'b1;
              state_q <= LONG;
            end
          end else begin
            state_q     <= REL_WAIT;
            dcnt_q      <= DONE;
            from_long_q <= 1'b0;
          end
        end
        LONG: begin
          if (!p) begin
            state_q     <= REL_WAIT;
            dcnt_q      <= DONE;
            from_long_q <= 1'b1;
          end
        end
        REL_WAIT: begin
          // A glitch resumes the held state with hcnt untouched.
          if (p) begin
            state_q <= from_long_q ? LONG : PRESSED;
          end else if (dcnt_q == DLAST) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_reader.sv
module tb_button_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  button_reader #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; an input driven at a falling edge
  // with cyc == t is first sampled at edge t+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic [7:0] cnt;
    logic       lvl;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int n_press = 0, n_rel = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, expv, cyc);
  endtask

  task automatic push(input logic [2:0] k, input int c, input logic [7:0] n, input logic l);
    exp_t e;
    e.kind = k; e.cyc = c; e.cnt = n; e.lvl = l;
    q.push_back(e);
  endtask

  // Monitor: any strobe pops the next expected event and compares it.
  initial begin
    exp_t e;
    logic [2:0] k;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_chk++;
        $display("FAIL missed_event: kind %b expected at cyc %0d, no strobe by cyc %0d", e.kind, e.cyc, cyc);
      end
      k = {press_pulse, release_pulse, long_pulse};
      if (k != 3'b000) begin
        if (press_pulse)   n_press++;
        if (release_pulse) n_rel++;
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got kind %b at cyc %0d, expected none", k, cyc);
        end else begin
          e = q.pop_front();
          chk("event_kind", int'(k), int'(e.kind));
          chk("event_cycle", cyc, e.cyc);
          chk("event_count", int'(press_count), int'(e.cnt));
          chk("event_level", int'(btn_level), int'(e.lvl));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Bounded wait for all expected events, then a few idle cycles so stray
  // strobes are caught before the next scenario.
  task automatic drain;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", q.size());
      q.delete();
    end
    tick(3);
  endtask

  task automatic do_reset;
    btn_in = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int t0, t1, tr, np0, nr0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_release", int'(release_pulse), 0);
    chk("rst_long", int'(long_pulse), 0);
    chk("rst_count", int'(press_count), 0);
    rst = 1'b0;
    tick(2);

    // Clean press, long press, release
    t0 = cyc;
    btn_in = 1'b0;
    push(K_PRESS, t0 + 6, 8'd1, 1'b1);
    push(K_LONG, t0 + 16, 8'd1, 1'b1);
    wait_until(t0 + 5);
    chk("clean_level_before", int'(btn_level), 0);
    wait_until(t0 + 10);
    chk("clean_level_held", int'(btn_level), 1);
    chk("clean_count", int'(press_count), 1);
    wait_until(t0 + 20);
    t1 = cyc;
    btn_in = 1'b1;
    push(K_REL, t1 + 6, 8'd1, 1'b0);
    drain();
    chk("clean_level_after", int'(btn_level), 0);

    // Bounce: low 3 edges, high 1, then low
    do_reset();
    t0 = cyc;
    btn_in = 1'b0;
    tick(3);
    btn_in = 1'b1;
    tick(1);
    btn_in = 1'b0;
    push(K_PRESS, t0 + 10, 8'd1, 1'b1);
    wait_until(t0 + 12);
    t1 = cyc;
    btn_in = 1'b1;
    push(K_REL, t1 + 6, 8'd1, 1'b0);
    drain();

    // Release glitch in PRESSED: 3 edges of paused hold count
    do_reset();
    t0 = cyc;
    btn_in = 1'b0;
    push(K_PRESS, t0 + 6, 8'd1, 1'b1);
    wait_until(t0 + 8);
    btn_in = 1'b1;
    wait_until(t0 + 10);
    btn_in = 1'b0;
    push(K_LONG, t0 + 19, 8'd1, 1'b1);
    wait_until(t0 + 12);
    chk("glitch_level_a", int'(btn_level), 1);
    wait_until(t0 + 13);
    chk("glitch_level_b", int'(btn_level), 1);
    wait_until(t0 + 22);
    t1 = cyc;
    btn_in = 1'b1;
    push(K_REL, t1 + 6, 8'd1, 1'b0);
    drain();

    // Reset while in LONG with the key held
    do_reset();
    t0 = cyc;
    btn_in = 1'b0;
    push(K_PRESS, t0 + 6, 8'd1, 1'b1);
    push(K_LONG, t0 + 16, 8'd1, 1'b1);
    wait_until(t0 + 20);
    rst = 1'b1;
    tick(1);
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_count", int'(press_count), 0);
    chk("midrst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    rst = 1'b0;
    tr = cyc;
    push(K_PRESS, tr + 6, 8'd1, 1'b1);
    wait_until(tr + 8);
    chk("midrst_count_after", int'(press_count), 1);
    t1 = cyc;
    btn_in = 1'b1;
    push(K_REL, t1 + 6, 8'd1, 1'b0);
    drain();

    // Wrap: 256 clean press/release pairs
    do_reset();
    np0 = n_press;
    nr0 = n_rel;
    for (int i = 1; i <= 256; i++) begin
      t0 = cyc;
      btn_in = 1'b0;
      push(K_PRESS, t0 + 6, 8'(i), 1'b1);
      tick(8);
      t1 = cyc;
      btn_in = 1'b1;
      push(K_REL, t1 + 6, 8'(i), 1'b0);
      tick(8);
    end
    drain();
    chk("wrap_presses", n_press - np0, 256);
    chk("wrap_releases", n_rel - nr0, 256);
    chk("wrap_count", int'(press_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
